ltssm_detect_polling: RTL and testbench

//  Parametrised, multi-lane LTSSM front end. It covers Detect.Quiet, Detect.Active, Polling.Active,

---
 rtl/ltssm_pkg.sv | 33 +++
 rtl/lane_ts_counter.sv | 41 ++++
 rtl/ltssm_detect_polling.sv | 250 +++++++++++++++++++++++++
 tb/tb_ltssm_detect_polling.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltssm_pkg.sv
// Shared types and defaults for the LTSSM Detect/Polling front end.
//   ltssm_sub_e : sub-state encoding reported on state_o
//   *_DEF       : default timing/count limits (scaled from the real-time values)
//   max_u       : larger of two values, for sizing shared counters
//   cnt_width   : bits needed to hold 0..limit inclusive (at least 1)
package ltssm_pkg;

  typedef enum logic [2:0] {
    DET_QUIET   = 3'd0,
    DET_ACTIVE  = 3'd1,
    POLL_ACTIVE = 3'd2,
    POLL_COMPL  = 3'd3,
    POLL_CONFIG = 3'd4,
    CONFIG      = 3'd5
  } ltssm_sub_e;

  localparam int unsigned NUM_LANES_DEF    = 4;
  localparam int unsigned QUIET_CYC_DEF    = 1200;
  localparam int unsigned POLL_ACT_CYC_DEF = 2400;
  localparam int unsigned POLL_CFG_CYC_DEF = 4800;
  localparam int unsigned TS1_TX_MIN_DEF   = 1024;
  localparam int unsigned TS2_TX_MIN_DEF   = 16;
  localparam int unsigned TS_RX_MIN_DEF    = 8;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/lane_ts_counter.sv
// Per-lane consecutive-TS counter.
//   clk_i, rst_ni : clock, synchronous active-low reset
//   inc_i         : an expected-type TS arrived on this lane
//   clr_i         : break in the consecutive run (other OS, wrong TS type, state entry)
//   qualified_o   : LIMIT consecutive TS seen; count saturates there
module lane_ts_counter
  import ltssm_pkg::*;
#(
  parameter int unsigned LIMIT = TS_RX_MIN_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic inc_i,
  input  logic clr_i,
  output logic qualified_o
);

  localparam int unsigned W = cnt_width(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign qualified_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/ltssm_detect_polling.sv
// Multi-lane LTSSM front end: Detect.Quiet/Active, Polling.Active/Compliance/
// Configuration, then handoff to Configuration.
//   clk_i, rst_ni      : clock, synchronous active-low reset
//   restart_i          : directed return to DET_QUIET (clears lane mask)
//   compliance_i       : directed Polling.Compliance entry/hold
//   rx_eidle_exit_i    : per-lane electrical-idle exit
//   rx_det_done_i/rx_det_i : receiver-detect complete pulse / per-lane presence
//   rx_ts1_i/rx_ts2_i  : per-lane TS1/TS2 received pulses
//   rx_os_other_i      : per-lane non-TS ordered set (breaks consecutive count)
//   tx_os_sent_i       : one TS sent on all enabled lanes
//   det_req_o          : receiver-detect request pulse
//   tx_lane_en_o       : lanes driving TS (lane mask in Polling/Config)
//   tx_ts1_o/tx_ts2_o/tx_compl_o : transmit TS1 / TS2 / compliance pattern
//   cfg_start_o        : Configuration entered (level)
//   state_o            : current sub-state
// All outputs except state_o are registered from the current state, so they
// follow a transition by one cycle.
module ltssm_detect_polling
  import ltssm_pkg::*;
#(
  parameter int unsigned NUM_LANES    = NUM_LANES_DEF,
  parameter int unsigned QUIET_CYC    = QUIET_CYC_DEF,
  parameter int unsigned POLL_ACT_CYC = POLL_ACT_CYC_DEF,
  parameter int unsigned POLL_CFG_CYC = POLL_CFG_CYC_DEF,
  parameter int unsigned TS1_TX_MIN   = TS1_TX_MIN_DEF,
  parameter int unsigned TS2_TX_MIN   = TS2_TX_MIN_DEF,
  parameter int unsigned TS_RX_MIN    = TS_RX_MIN_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 restart_i,
  input  logic                 compliance_i,
  input  logic [NUM_LANES-1:0] rx_eidle_exit_i,
  input  logic                 rx_det_done_i,
  input  logic [NUM_LANES-1:0] rx_det_i,
  input  logic [NUM_LANES-1:0] rx_ts1_i,
  input  logic [NUM_LANES-1:0] rx_ts2_i,
  input  logic [NUM_LANES-1:0] rx_os_other_i,
  input  logic                 tx_os_sent_i,
  output logic                 det_req_o,
  output logic [NUM_LANES-1:0] tx_lane_en_o,
  output logic                 tx_ts1_o,
  output logic                 tx_ts2_o,
  output logic                 tx_compl_o,
  output logic                 cfg_start_o,
  output logic [2:0]           state_o
);

  localparam int unsigned TMR_MAX = max_u(max_u(QUIET_CYC, POLL_ACT_CYC), POLL_CFG_CYC);
  localparam int unsigned TMR_W   = cnt_width(TMR_MAX);
  localparam int unsigned TX_MAX  = max_u(TS1_TX_MIN, TS2_TX_MIN);
  localparam int unsigned TX_W    = cnt_width(TX_MAX);

  ltssm_sub_e           state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [TX_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic                 ts2_seen_q, ts2_seen_d;
  logic [NUM_LANES-1:0] mask_q, mask_d;

  logic                 det_req_q, det_req_d;
  logic [NUM_LANES-1:0] tx_lane_en_q, tx_lane_en_d;
  logic                 tx_ts1_q, tx_ts1_d;
  logic                 tx_ts2_q, tx_ts2_d;
  logic                 tx_compl_q, tx_compl_d;
  logic                 cfg_start_q, cfg_start_d;

  logic [NUM_LANES-1:0] lane_qual, lane_inc, lane_clr;
  logic                 all_qual, any_qual;
  logic                 ts1_tx_met, ts2_tx_met;
  logic                 entry;
  logic                 tx_cnt_en;
  logic [TX_W-1:0]      tx_lim;

  // ---------------------------------------------------------------------------
  // Per-lane consecutive-TS counters
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_inc = '0;
    lane_clr = rx_os_other_i | {NUM_LANES{entry}};
    case (state_q)
      POLL_ACTIVE: lane_inc = rx_ts1_i | rx_ts2_i;
      POLL_CONFIG: begin
        lane_inc = rx_ts2_i;
        lane_clr = lane_clr | rx_ts1_i;
      end
      default:     lane_clr = '1;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_ts_counter #(
      .LIMIT (TS_RX_MIN)
    ) u_cnt (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .inc_i       (lane_inc[g]),
      .clr_i       (lane_clr[g]),
      .qualified_o (lane_qual[g])
    );
  end

  // Lanes outside the mask are treated as qualified so they never block exit.
  assign all_qual   = &(lane_qual | ~mask_q);
  assign any_qual   = |(lane_qual & mask_q);
  assign ts1_tx_met = (tx_cnt_q >= TX_W'(TS1_TX_MIN));
  assign ts2_tx_met = (tx_cnt_q >= TX_W'(TS2_TX_MIN));

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    if (restart_i) begin
      state_d = DET_QUIET;
      mask_d  = '0;
    end else begin
      case (state_q)
        DET_QUIET: begin
          if ((timer_q == TMR_W'(QUIET_CYC - 1)) || (|rx_eidle_exit_i)) begin
            state_d = DET_ACTIVE;
          end
        end
        DET_ACTIVE: begin
          if (rx_det_done_i) begin
            if (|rx_det_i) begin
              mask_d  = rx_det_i;
              state_d = POLL_ACTIVE;
            end else begin
              state_d = DET_QUIET;
            end
          end
        end
        POLL_ACTIVE: begin
          if (compliance_i) begin
            state_d = POLL_COMPL;
          end else if (ts1_tx_met && all_qual) begin
            state_d = POLL_CONFIG;
          end else if (timer_q == TMR_W'(POLL_ACT_CYC - 1)) begin
            // Partial link: continue on the lanes that did qualify.
            if (ts1_tx_met && any_qual) begin
              mask_d  = mask_q & lane_qual;
              state_d = POLL_CONFIG;
            end else begin
              state_d = DET_QUIET;
            end
          end
        end
        POLL_COMPL: begin
          if (!compliance_i) begin
            state_d = POLL_ACTIVE;
          end
        end
        POLL_CONFIG: begin
          if (all_qual && ts2_tx_met) begin
            state_d = CONFIG;
          end else if (timer_q == TMR_W'(POLL_CFG_CYC - 1)) begin
            state_d = DET_QUIET;
          end
        end
        CONFIG:  state_d = CONFIG;
        default: state_d = DET_QUIET;
      endcase
    end
  end

  // A restart counts as an entry even when already in DET_QUIET.
  assign entry = restart_i || (state_d != state_q);

  // ---------------------------------------------------------------------------
  // State timer, TX counter, TS2-seen flag
  // ---------------------------------------------------------------------------
  always_comb begin
    timer_d    = timer_q;
    ts2_seen_d = ts2_seen_q;
    tx_cnt_d   = tx_cnt_q;
    tx_cnt_en  = 1'b0;
    tx_lim     = (state_q == POLL_CONFIG) ? TX_W'(TS2_TX_MIN) : TX_W'(TS1_TX_MIN);
    if (entry) begin
      timer_d    = '0;
      ts2_seen_d = 1'b0;
      tx_cnt_d   = '0;
    end else begin
      if (timer_q != TMR_W'(TMR_MAX)) begin
        timer_d = timer_q + 1'b1;
      end
      // In POLL_CONFIG the TX count starts with the cycle of the first masked TS2.
      if ((state_q == POLL_CONFIG) && (|(rx_ts2_i & mask_q))) begin
        ts2_seen_d = 1'b1;
      end
      tx_cnt_en = (state_q == POLL_ACTIVE) || ((state_q == POLL_CONFIG) && ts2_seen_d);
      if (tx_cnt_en && tx_os_sent_i && (tx_cnt_q < tx_lim)) begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registered outputs, decoded from the current state
  // ---------------------------------------------------------------------------
  always_comb begin
    det_req_d    = (state_q == DET_ACTIVE) && (timer_q == '0);
    tx_ts1_d     = (state_q == POLL_ACTIVE);
    tx_compl_d   = (state_q == POLL_COMPL);
    tx_ts2_d     = (state_q == POLL_CONFIG);
    cfg_start_d  = (state_q == CONFIG);
    tx_lane_en_d = '0;
    if ((state_q == POLL_ACTIVE) || (state_q == POLL_COMPL) ||
        (state_q == POLL_CONFIG) || (state_q == CONFIG)) begin
      tx_lane_en_d = mask_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= DET_QUIET;
      timer_q      <= '0;
      tx_cnt_q     <= '0;
      ts2_seen_q   <= 1'b0;
      mask_q       <= '0;
      det_req_q    <= 1'b0;
      tx_lane_en_q <= '0;
      tx_ts1_q     <= 1'b0;
      tx_ts2_q     <= 1'b0;
      tx_compl_q   <= 1'b0;
      cfg_start_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      tx_cnt_q     <= tx_cnt_d;
      ts2_seen_q   <= ts2_seen_d;
      mask_q       <= mask_d;
      det_req_q    <= det_req_d;
      tx_lane_en_q <= tx_lane_en_d;
      tx_ts1_q     <= tx_ts1_d;
      tx_ts2_q     <= tx_ts2_d;
      tx_compl_q   <= tx_compl_d;
      cfg_start_q  <= cfg_start_d;
    end
  end

  assign det_req_o    = det_req_q;
  assign tx_lane_en_o = tx_lane_en_q;
  assign tx_ts1_o     = tx_ts1_q;
  assign tx_ts2_o     = tx_ts2_q;
  assign tx_compl_o   = tx_compl_q;
  assign cfg_start_o  = cfg_start_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_ltssm_detect_polling.sv
// Randomized bench for ltssm_detect_polling with a lock-step behavioural model.
module tb_ltssm_detect_polling;

  localparam int NL  = 4;
  localparam int QC  = 1200;
  localparam int PAC = 2400;
  localparam int PCC = 4800;
  localparam int T1  = 1024;
  localparam int T2  = 16;
  localparam int RX  = 8;

  // state_o values in the order the sub-states are listed
  localparam int S_DQ = 0, S_DA = 1, S_PA = 2, S_PCM = 3, S_PCF = 4, S_CFG = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_ni, restart_i, compliance_i, rx_det_done_i, tx_os_sent_i;
  logic [NL-1:0] rx_eidle_exit_i, rx_det_i, rx_ts1_i, rx_ts2_i, rx_os_other_i;
  logic          det_req_o, tx_ts1_o, tx_ts2_o, tx_compl_o, cfg_start_o;
  logic [NL-1:0] tx_lane_en_o;
  logic [2:0]    state_o;

  ltssm_detect_polling #(
    .NUM_LANES    (NL),
    .QUIET_CYC    (QC),
    .POLL_ACT_CYC (PAC),
    .POLL_CFG_CYC (PCC),
    .TS1_TX_MIN   (T1),
    .TS2_TX_MIN   (T2),
    .TS_RX_MIN    (RX)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .restart_i       (restart_i),
    .compliance_i    (compliance_i),
    .rx_eidle_exit_i (rx_eidle_exit_i),
    .rx_det_done_i   (rx_det_done_i),
    .rx_det_i        (rx_det_i),
    .rx_ts1_i        (rx_ts1_i),
    .rx_ts2_i        (rx_ts2_i),
    .rx_os_other_i   (rx_os_other_i),
    .tx_os_sent_i    (tx_os_sent_i),
    .det_req_o       (det_req_o),
    .tx_lane_en_o    (tx_lane_en_o),
    .tx_ts1_o        (tx_ts1_o),
    .tx_ts2_o        (tx_ts2_o),
    .tx_compl_o      (tx_compl_o),
    .cfg_start_o     (cfg_start_o),
    .state_o         (state_o)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: age = cycles since entering the state, counts are plain
  // unbounded integers compared against the limits.
  // ---------------------------------------------------------------------------
  int            m_state, m_age, m_tx;
  bit            m_seen;
  int            m_cnt[NL];
  logic [NL-1:0] m_mask;
  bit            m_det_req, m_ts1, m_ts2, m_compl, m_cfg;
  logic [NL-1:0] m_en;

  task automatic model_step();
    int            nxt;
    logic [NL-1:0] q, new_mask;
    bit            all_q, any_q, entered;
    if (!rst_ni) begin
      m_state = S_DQ; m_age = 0; m_tx = 0; m_seen = 0; m_mask = '0;
      for (int l = 0; l < NL; l++) m_cnt[l] = 0;
      m_det_req = 0; m_ts1 = 0; m_ts2 = 0; m_compl = 0; m_cfg = 0; m_en = '0;
      return;
    end
    m_det_req = (m_state == S_DA) && (m_age == 0);
    m_ts1     = (m_state == S_PA);
    m_compl   = (m_state == S_PCM);
    m_ts2     = (m_state == S_PCF);
    m_cfg     = (m_state == S_CFG);
    m_en      = (m_state >= S_PA) ? m_mask : '0;

    for (int l = 0; l < NL; l++) q[l] = (m_cnt[l] >= RX);
    all_q = ((q & m_mask) == m_mask);
    any_q = ((q & m_mask) != '0);

    nxt = m_state;
    new_mask = m_mask;
    if (restart_i) begin
      nxt = S_DQ;
      new_mask = '0;
    end else begin
      case (m_state)
        S_DQ:  if (m_age == QC - 1 || rx_eidle_exit_i != '0) nxt = S_DA;
        S_DA:  if (rx_det_done_i) begin
                 if (rx_det_i != '0) begin nxt = S_PA; new_mask = rx_det_i; end
                 else nxt = S_DQ;
               end
        S_PA:  if (compliance_i) nxt = S_PCM;
               else if (m_tx >= T1 && all_q) nxt = S_PCF;
               else if (m_age == PAC - 1) begin
                 if (m_tx >= T1 && any_q) begin nxt = S_PCF; new_mask = q & m_mask; end
                 else nxt = S_DQ;
               end
        S_PCM: if (!compliance_i) nxt = S_PA;
        S_PCF: if (all_q && m_tx >= T2) nxt = S_CFG;
               else if (m_age == PCC - 1) nxt = S_DQ;
        default: ;
      endcase
    end

    entered = restart_i || (nxt != m_state);
    if (entered) begin
      m_age = 0; m_tx = 0; m_seen = 0;
      for (int l = 0; l < NL; l++) m_cnt[l] = 0;
    end else begin
      m_age++;
      if (m_state == S_PA && tx_os_sent_i) m_tx++;
      if (m_state == S_PCF) begin
        if ((rx_ts2_i & m_mask) != '0) m_seen = 1;
        if (m_seen && tx_os_sent_i) m_tx++;
      end
      for (int l = 0; l < NL; l++) begin
        if (rx_os_other_i[l]) m_cnt[l] = 0;
        else if (m_state == S_PA) begin
          if (rx_ts1_i[l] || rx_ts2_i[l]) m_cnt[l]++;
        end else if (m_state == S_PCF) begin
          if (rx_ts1_i[l]) m_cnt[l] = 0;
          else if (rx_ts2_i[l]) m_cnt[l]++;
        end else m_cnt[l] = 0;
      end
    end
    m_state = nxt;
    m_mask  = new_mask;
  endtask

  task automatic compare_all();
    check_eq("state",      32'(state_o),      32'(m_state));
    check_eq("det_req",    32'(det_req_o),    32'(m_det_req));
    check_eq("tx_lane_en", 32'(tx_lane_en_o), 32'(m_en));
    check_eq("tx_ts1",     32'(tx_ts1_o),     32'(m_ts1));
    check_eq("tx_ts2",     32'(tx_ts2_o),     32'(m_ts2));
    check_eq("tx_compl",   32'(tx_compl_o),   32'(m_compl));
    check_eq("cfg_start",  32'(cfg_start_o),  32'(m_cfg));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus: link-partner behaviour shaped by per-trial knobs
  // ---------------------------------------------------------------------------
  logic [NL-1:0] k_det, k_live;
  bit            k_eidle, k_compl, k_ts2pa, k_rst_pcf;
  int            k_other, k_budget;
  int            compl_left, compl_cnt;
  bit            rst_pcf_used;

  task automatic clear_inputs();
    restart_i = 0; compliance_i = 0; rx_det_done_i = 0; tx_os_sent_i = 0;
    rx_eidle_exit_i = '0; rx_det_i = '0; rx_ts1_i = '0; rx_ts2_i = '0; rx_os_other_i = '0;
  endtask

  task automatic drive_inputs();
    logic [NL-1:0] t1, t2, oth;
    t1 = '0; t2 = '0; oth = '0;
    restart_i = 0;
    rx_eidle_exit_i = '0;
    if (m_state == S_DQ) begin
      if (k_eidle && $urandom_range(0, 39) == 0) rx_eidle_exit_i = NL'($urandom_range(1, (1 << NL) - 1));
    end else if ($urandom_range(0, 9) == 0) rx_eidle_exit_i = NL'($urandom);
    rx_det_done_i = (m_state == S_DA) && (m_age >= 1) && ($urandom_range(0, 7) == 0);
    rx_det_i      = rx_det_done_i ? k_det : NL'($urandom);
    tx_os_sent_i  = ($urandom_range(0, 3) != 0);
    for (int l = 0; l < NL; l++) begin
      if (k_live[l]) begin
        if (m_state == S_PA) begin
          if ($urandom_range(0, 2) == 0) begin
            if (k_ts2pa && $urandom_range(0, 1) == 1) t2[l] = 1;
            else t1[l] = 1;
          end
        end else if (m_state == S_PCF) begin
          if ($urandom_range(0, 39) == 0) t1[l] = 1;
          else if ($urandom_range(0, 2) == 0) t2[l] = 1;
        end else if ($urandom_range(0, 7) == 0) t1[l] = 1;
      end
      if (k_other != 0 && $urandom_range(0, k_other - 1) == 0) oth[l] = 1;
    end
    rx_ts1_i = t1; rx_ts2_i = t2; rx_os_other_i = oth;
    if (compl_left > 0) compl_left--;
    else if (k_compl && compl_cnt < 2 && m_state == S_PA && m_age > 40 &&
             $urandom_range(0, 299) == 0) begin
      compl_left = $urandom_range(5, 40);
      compl_cnt++;
    end
    compliance_i = (compl_left > 0);
    if (k_rst_pcf && !rst_pcf_used && m_state == S_PCF && m_age == 10) begin
      restart_i = 1;
      rst_pcf_used = 1;
    end else if ($urandom_range(0, 4999) == 0) restart_i = 1;
  endtask

  task automatic run_trial(input bit use_reset);
    bit done;
    done = 0;
    compl_left = 0; compl_cnt = 0; rst_pcf_used = 0;
    for (int c = 0; c < k_budget && !done && n_bad < 500; c++) begin
      drive_inputs();
      if (m_state == S_CFG && m_age >= 20) done = 1;
      cycle();
    end
    clear_inputs();
    if (use_reset) rst_ni = 0;
    else restart_i = 1;
    cycle();
    rst_ni = 1;
    restart_i = 0;
    cycle();
  endtask

  initial begin
    clear_inputs();
    rst_ni = 0;
    repeat (3) cycle();
    rst_ni = 1;
    for (int t = 0; t < 14 && n_bad < 500; t++) begin
      k_budget = 7000; k_eidle = 1; k_compl = 0; k_ts2pa = 0; k_rst_pcf = 0; k_other = 0;
      case (t)
        0: begin k_det = 4'b0000; k_live = 4'b0000; k_eidle = 0; k_budget = 1400; end
        1: begin k_det = 4'b1011; k_live = 4'b1011; end
        2: begin k_det = 4'b1111; k_live = 4'b1011; end
        3: begin k_det = 4'b0001; k_live = 4'b0001; k_other = 12; end
        4: begin k_det = 4'b1111; k_live = 4'b1111; k_compl = 1; end
        5: begin k_det = 4'b1011; k_live = 4'b1011; k_rst_pcf = 1; k_ts2pa = 1; end
        default: begin
          k_det     = NL'($urandom);
          k_live    = ($urandom_range(0, 1) == 0) ? k_det : (k_det & NL'($urandom));
          k_eidle   = ($urandom_range(0, 3) != 0);
          k_compl   = $urandom_range(0, 1);
          k_ts2pa   = $urandom_range(0, 1);
          k_rst_pcf = ($urandom_range(0, 3) == 0);
          case ($urandom_range(0, 2))
            0: k_other = 0;
            1: k_other = 40;
            default: k_other = 200;
          endcase
        end
      endcase
      run_trial(t % 2 == 1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion before limit");
    $fatal(1, "time limit");
  end

endmodule
